// File: rtl/pipe_pkg.sv
// Shared pipeline constants: ALU operation codes, aluOp and funct encodings,
// forwarding-select encoding and the ID/EX control bundle.
package pipe_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic alu_src;
        logic reg_dst;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between the ID stage / forwarding sources and the ID/EX stage.
// master = upstream pipeline driving decode and forwarding data,
// slave  = the ID/EX stage itself.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              idValid;
    logic [REG_W-1:0]  idRs;
    logic [REG_W-1:0]  idRt;
    logic [REG_W-1:0]  idRd;
    logic [DATA_W-1:0] idRsData;
    logic [DATA_W-1:0] idRtData;
    logic [15:0]       idImm;
    logic [5:0]        idFunct;
    logic [1:0]        idAluOp;
    logic              idAluSrc;
    logic              idRegDst;
    logic              idMemRead;
    logic              idMemWrite;
    logic              idMemToReg;
    logic              idRegWrite;
    logic              idBranch;
    logic              flush;

    logic              exMemRegWrite;
    logic [REG_W-1:0]  exMemRd;
    logic [DATA_W-1:0] exMemAluRes;
    logic              memWbRegWrite;
    logic [REG_W-1:0]  memWbRd;
    logic [DATA_W-1:0] memWbData;

    logic              stall;
    logic [DATA_W-1:0] input1;
    logic [DATA_W-1:0] input2;
    logic [3:0]        aluCtr;
    logic [DATA_W-1:0] exStoreData;
    logic [REG_W-1:0]  exWriteReg;
    logic              exValid;
    logic              exMemRead;
    logic              exMemWrite;
    logic              exMemToReg;
    logic              exRegWrite;
    logic              exBranch;

    modport master (
        output idValid, idRs, idRt, idRd, idRsData, idRtData, idImm, idFunct,
               idAluOp, idAluSrc, idRegDst, idMemRead, idMemWrite, idMemToReg,
               idRegWrite, idBranch, flush,
               exMemRegWrite, exMemRd, exMemAluRes, memWbRegWrite, memWbRd, memWbData,
        input  stall, input1, input2, aluCtr, exStoreData, exWriteReg, exValid,
               exMemRead, exMemWrite, exMemToReg, exRegWrite, exBranch
    );

    modport slave (
        input  idValid, idRs, idRt, idRd, idRsData, idRtData, idImm, idFunct,
               idAluOp, idAluSrc, idRegDst, idMemRead, idMemWrite, idMemToReg,
               idRegWrite, idBranch, flush,
               exMemRegWrite, exMemRd, exMemAluRes, memWbRegWrite, memWbRd, memWbData,
        output stall, input1, input2, aluCtr, exStoreData, exWriteReg, exValid,
               exMemRead, exMemWrite, exMemToReg, exRegWrite, exBranch
    );

endinterface

// File: rtl/forward_unit.sv
// Forwarding select for one source register. EX/MEM is the younger result
// and therefore wins over MEM/WB; register 0 is never forwarded.
module forward_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             ex_mem_reg_write_i,
    input  logic [REG_W-1:0] ex_mem_rd_i,
    input  logic             mem_wb_reg_write_i,
    input  logic [REG_W-1:0] mem_wb_rd_i,
    output fwd_sel_e         sel_o
);

    // Priority select: EX/MEM, then MEM/WB, then register-file data.
    always_comb begin
        sel_o = FWD_REG;
        if (ex_mem_reg_write_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (mem_wb_reg_write_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == src_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, operand forwarding and
// load-use hazard detection. Operands leave combinationally toward the ALU.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic        clk,
    input  logic        reset,
    id_ex_stage_if.slave bus
);

    logic              valid_q,   valid_d;
    ctrl_t             ctrl_q,    ctrl_d;
    logic [REG_W-1:0]  rs_q,      rs_d;
    logic [REG_W-1:0]  rt_q,      rt_d;
    logic [REG_W-1:0]  rd_q,      rd_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [1:0]        alu_op_q,  alu_op_d;
    logic [5:0]        funct_q,   funct_d;

    logic              stall;
    logic              bubble;
    fwd_sel_e          rs_sel;
    fwd_sel_e          rt_sel;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic [3:0]        alu_ctr;

    // Load-use: the load in EX cannot supply its data before the next cycle.
    assign stall = valid_q & ctrl_q.mem_read & (rt_q != '0) & bus.idValid &
                   ((bus.idRs == rt_q) | (bus.idRt == rt_q));

    assign bubble = bus.flush | stall;

    // Next ID/EX contents: a bubble loads all zeros, which clears valid and
    // every control bit; data fields are irrelevant in a bubble.
    always_comb begin
        valid_d   = 1'b0;
        ctrl_d    = '0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        alu_op_d  = '0;
        funct_d   = '0;
        if (!bubble) begin
            valid_d           = bus.idValid;
            ctrl_d.alu_src    = bus.idAluSrc;
            ctrl_d.reg_dst    = bus.idRegDst;
            ctrl_d.mem_read   = bus.idMemRead;
            ctrl_d.mem_write  = bus.idMemWrite;
            ctrl_d.mem_to_reg = bus.idMemToReg;
            ctrl_d.reg_write  = bus.idRegWrite;
            ctrl_d.branch     = bus.idBranch;
            rs_d              = bus.idRs;
            rt_d              = bus.idRt;
            rd_d              = bus.idRd;
            rs_data_d         = bus.idRsData;
            rt_data_d         = bus.idRtData;
            imm_d             = {{(DATA_W-16){bus.idImm[15]}}, bus.idImm};
            alu_op_d          = bus.idAluOp;
            funct_d           = bus.idFunct;
        end
    end

    // ID/EX register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            alu_op_q  <= '0;
            funct_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            alu_op_q  <= alu_op_d;
            funct_q   <= funct_d;
        end
    end

    forward_unit #(.REG_W(REG_W)) u_fwd_rs (
        .src_i              (rs_q),
        .ex_mem_reg_write_i (bus.exMemRegWrite),
        .ex_mem_rd_i        (bus.exMemRd),
        .mem_wb_reg_write_i (bus.memWbRegWrite),
        .mem_wb_rd_i        (bus.memWbRd),
        .sel_o              (rs_sel)
    );

    forward_unit #(.REG_W(REG_W)) u_fwd_rt (
        .src_i              (rt_q),
        .ex_mem_reg_write_i (bus.exMemRegWrite),
        .ex_mem_rd_i        (bus.exMemRd),
        .mem_wb_reg_write_i (bus.memWbRegWrite),
        .mem_wb_rd_i        (bus.memWbRd),
        .sel_o              (rt_sel)
    );

    // Operand muxes driven by the forwarding selects.
    always_comb begin
        rs_fwd = rs_data_q;
        rt_fwd = rt_data_q;
        case (rs_sel)
            FWD_EXMEM: rs_fwd = bus.exMemAluRes;
            FWD_MEMWB: rs_fwd = bus.memWbData;
            default:   rs_fwd = rs_data_q;
        endcase
        case (rt_sel)
            FWD_EXMEM: rt_fwd = bus.exMemAluRes;
            FWD_MEMWB: rt_fwd = bus.memWbData;
            default:   rt_fwd = rt_data_q;
        endcase
    end

    // ALU control decode from the registered aluOp/funct; reserved aluOp adds.
    always_comb begin
        alu_ctr = ALU_ADD;
        case (alu_op_q)
            ALUOP_ADD, ALUOP_RSVD: alu_ctr = ALU_ADD;
            ALUOP_SUB:             alu_ctr = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct_q)
                    FUNCT_ADD: alu_ctr = ALU_ADD;
                    FUNCT_SUB: alu_ctr = ALU_SUB;
                    FUNCT_AND: alu_ctr = ALU_AND;
                    FUNCT_OR:  alu_ctr = ALU_OR;
                    FUNCT_SLT: alu_ctr = ALU_SLT;
                    FUNCT_NOR: alu_ctr = ALU_NOR;
                    default:   alu_ctr = ALU_ADD;
                endcase
            end
            default: alu_ctr = ALU_ADD;
        endcase
    end

    assign bus.stall       = stall;
    assign bus.input1      = rs_fwd;
    assign bus.input2      = ctrl_q.alu_src ? imm_q : rt_fwd;
    assign bus.exStoreData = rt_fwd;
    assign bus.aluCtr      = alu_ctr;
    assign bus.exWriteReg  = ctrl_q.reg_dst ? rd_q : rt_q;
    assign bus.exValid     = valid_q;
    assign bus.exMemRead   = ctrl_q.mem_read;
    assign bus.exMemWrite  = ctrl_q.mem_write;
    assign bus.exMemToReg  = ctrl_q.mem_to_reg;
    assign bus.exRegWrite  = ctrl_q.reg_write;
    assign bus.exBranch    = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: fixed vector table, hand-written hazard sequences
// and randomized traffic checked against a reference model of the stage.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsData, rtData;
        logic [15:0] imm;
        logic [5:0]  funct;
        logic [1:0]  aluOp;
        logic        aluSrc, regDst, memRead, memWrite, memToReg, regWrite, branch;
    } id_t;

    typedef struct packed {
        logic        exW;
        logic [4:0]  exRd;
        logic [31:0] exRes;
        logic        wbW;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
    } fw_t;

    typedef struct {
        id_t         id;
        fw_t         fw;
        logic [31:0] in1, in2;
        logic [3:0]  ctr;
        logic [4:0]  wreg;
    } vec_t;

    int checks = 0;
    int errors = 0;

    id_t  cur_id;      // what the bench is presenting in ID
    id_t  m;           // model of the instruction held in EX
    logic m_known;     // data fields of m are meaningful (not a bubble)
    logic started = 1'b0;
    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic id_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                               input logic [5:0] funct, input logic [1:0] op,
                               input logic aluSrc, input logic regDst);
        id_t x;
        x = '0;
        x.valid = 1'b1; x.rs = rs; x.rt = rt; x.rd = rd;
        x.rsData = rsd; x.rtData = rtd; x.imm = imm; x.funct = funct; x.aluOp = op;
        x.aluSrc = aluSrc; x.regDst = regDst; x.regWrite = 1'b1;
        return x;
    endfunction

    function automatic fw_t mkfw(input logic exW, input logic [4:0] exRd, input logic [31:0] exRes,
                                 input logic wbW, input logic [4:0] wbRd, input logic [31:0] wbData);
        fw_t f;
        f.exW = exW; f.exRd = exRd; f.exRes = exRes;
        f.wbW = wbW; f.wbRd = wbRd; f.wbData = wbData;
        return f;
    endfunction

    // Reference: the youngest in-flight writer of a nonzero register supplies it.
    function automatic logic [31:0] ref_fwd(input logic [4:0] s, input logic [31:0] d);
        if (s == 0) return d;
        if (bus.exMemRegWrite && bus.exMemRd == s) return bus.exMemAluRes;
        if (bus.memWbRegWrite && bus.memWbRd == s) return bus.memWbData;
        return d;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b01) return 4'b0110;
        if (op != 2'b10) return 4'b0010;
        case (f)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            6'h27:   return 4'b1100;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic ref_stall();
        return m.valid && m.memRead && (m.rt != 0) && bus.idValid &&
               (bus.idRs == m.rt || bus.idRt == m.rt);
    endfunction

    task automatic drive_id(input id_t x);
        cur_id = x;
        bus.idValid = x.valid; bus.idRs = x.rs; bus.idRt = x.rt; bus.idRd = x.rd;
        bus.idRsData = x.rsData; bus.idRtData = x.rtData; bus.idImm = x.imm;
        bus.idFunct = x.funct; bus.idAluOp = x.aluOp; bus.idAluSrc = x.aluSrc;
        bus.idRegDst = x.regDst; bus.idMemRead = x.memRead; bus.idMemWrite = x.memWrite;
        bus.idMemToReg = x.memToReg; bus.idRegWrite = x.regWrite; bus.idBranch = x.branch;
    endtask

    task automatic drive_fw(input fw_t f);
        bus.exMemRegWrite = f.exW; bus.exMemRd = f.exRd; bus.exMemAluRes = f.exRes;
        bus.memWbRegWrite = f.wbW; bus.memWbRd = f.wbRd; bus.memWbData = f.wbData;
    endtask

    // One clock: check stall before the edge, then advance the model.
    task automatic step(input logic rst, input logic fl);
        logic st;
        reset = rst;
        bus.flush = fl;
        #1;
        st = ref_stall();
        if (started) chk("stall", 32'(bus.stall), 32'(st));
        @(posedge clk);
        if (rst) begin
            m = '0;
            m_known = 1'b1;
        end else if (fl || st) begin
            m.valid = 1'b0; m.regWrite = 1'b0; m.memRead = 1'b0;
            m.memWrite = 1'b0; m.branch = 1'b0;
            m_known = 1'b0;
        end else begin
            m = cur_id;
            m_known = 1'b1;
        end
        started = 1'b1;
        #1;
        reset = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic check_outs();
        logic [31:0] st_e, imm_e;
        #1;
        chk("exValid", 32'(bus.exValid), 32'(m.valid));
        chk("exRegWrite", 32'(bus.exRegWrite), 32'(m.regWrite));
        chk("exMemRead", 32'(bus.exMemRead), 32'(m.memRead));
        chk("exMemWrite", 32'(bus.exMemWrite), 32'(m.memWrite));
        chk("exBranch", 32'(bus.exBranch), 32'(m.branch));
        if (m_known) begin
            imm_e = 32'($signed(m.imm));
            st_e  = ref_fwd(m.rt, m.rtData);
            chk("exMemToReg", 32'(bus.exMemToReg), 32'(m.memToReg));
            chk("input1", bus.input1, ref_fwd(m.rs, m.rsData));
            chk("exStoreData", bus.exStoreData, st_e);
            chk("input2", bus.input2, m.aluSrc ? imm_e : st_e);
            chk("aluCtr", 32'(bus.aluCtr), 32'(ref_alu(m.aluOp, m.funct)));
            chk("exWriteReg", 32'(bus.exWriteReg), 32'(m.regDst ? m.rd : m.rt));
        end
    endtask

    task automatic setv(input int i, input id_t id, input fw_t fw, input logic [31:0] in1,
                        input logic [31:0] in2, input logic [3:0] ctr, input logic [4:0] wreg);
        vt[i].id = id; vt[i].fw = fw; vt[i].in1 = in1; vt[i].in2 = in2;
        vt[i].ctr = ctr; vt[i].wreg = wreg;
    endtask

    initial begin
        id_t  lw, dep, r;
        fw_t  fw0, rf;
        logic rst_r, fl_r;

        fw0 = '0;
        m = '0;
        m_known = 1'b0;
        reset = 1'b1;
        bus.flush = 1'b0;

        setv(0,  mk(1, 2, 9, 32'h5, 32'h7, 16'h0, 6'h20, 2'b10, 0, 1), fw0, 32'h5, 32'h7, 4'b0010, 5'd9);
        setv(1,  mk(3, 2, 10, 32'h11, 32'h7, 16'h0, 6'h20, 2'b10, 0, 1),
                 mkfw(1, 3, 32'hAA, 1, 3, 32'hBB), 32'hAA, 32'h7, 4'b0010, 5'd10);
        setv(2,  mk(3, 2, 10, 32'h11, 32'h7, 16'h0, 6'h20, 2'b10, 0, 1),
                 mkfw(0, 3, 32'hAA, 1, 3, 32'hBB), 32'hBB, 32'h7, 4'b0010, 5'd10);
        setv(3,  mk(3, 2, 10, 32'h11, 32'h7, 16'h0, 6'h20, 2'b10, 0, 1),
                 mkfw(1, 0, 32'hAA, 1, 0, 32'hBB), 32'h11, 32'h7, 4'b0010, 5'd10);
        setv(4,  mk(1, 6, 0, 32'h5, 32'h8, 16'hFFFC, 6'h0, 2'b00, 1, 0), fw0,
                 32'h5, 32'hFFFFFFFC, 4'b0010, 5'd6);
        setv(5,  mk(1, 6, 0, 32'h5, 32'h8, 16'hFFFC, 6'h0, 2'b01, 1, 0), fw0,
                 32'h5, 32'hFFFFFFFC, 4'b0110, 5'd6);
        setv(6,  mk(1, 2, 9, 32'h5, 32'h7, 16'h0, 6'h24, 2'b10, 0, 1), fw0, 32'h5, 32'h7, 4'b0000, 5'd9);
        setv(7,  mk(1, 2, 9, 32'h5, 32'h7, 16'h0, 6'h25, 2'b10, 0, 1), fw0, 32'h5, 32'h7, 4'b0001, 5'd9);
        setv(8,  mk(1, 2, 9, 32'h5, 32'h7, 16'h0, 6'h2A, 2'b10, 0, 1), fw0, 32'h5, 32'h7, 4'b0111, 5'd9);
        setv(9,  mk(1, 2, 9, 32'h5, 32'h7, 16'h0, 6'h27, 2'b10, 0, 1), fw0, 32'h5, 32'h7, 4'b1100, 5'd9);
        setv(10, mk(1, 2, 9, 32'h5, 32'h7, 16'h0, 6'h00, 2'b10, 0, 1), fw0, 32'h5, 32'h7, 4'b0010, 5'd9);
        setv(11, mk(1, 2, 9, 32'h5, 32'h7, 16'h0, 6'h22, 2'b10, 0, 1), fw0, 32'h5, 32'h7, 4'b0110, 5'd9);
        setv(12, mk(1, 2, 9, 32'h5, 32'h7, 16'h0, 6'h22, 2'b11, 0, 1), fw0, 32'h5, 32'h7, 4'b0010, 5'd9);
        setv(13, mk(1, 5, 9, 32'h5, 32'h7, 16'h0, 6'h20, 2'b10, 0, 1),
                 mkfw(0, 0, 32'h0, 1, 5, 32'h77), 32'h5, 32'h77, 4'b0010, 5'd9);

        // Reset state
        drive_id('0);
        drive_fw(fw0);
        step(1, 0);
        #1;
        chk("rst exValid", 32'(bus.exValid), 32'd0);
        chk("rst exRegWrite", 32'(bus.exRegWrite), 32'd0);
        chk("rst exMemRead", 32'(bus.exMemRead), 32'd0);
        chk("rst exWriteReg", 32'(bus.exWriteReg), 32'd0);
        chk("rst aluCtr", 32'(bus.aluCtr), 32'h2);
        chk("rst stall", 32'(bus.stall), 32'd0);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            drive_id(vt[i].id);
            drive_fw(fw0);
            step(0, 0);
            drive_fw(vt[i].fw);
            #1;
            chk($sformatf("vec%0d exValid", i), 32'(bus.exValid), 32'd1);
            chk($sformatf("vec%0d input1", i), bus.input1, vt[i].in1);
            chk($sformatf("vec%0d input2", i), bus.input2, vt[i].in2);
            chk($sformatf("vec%0d aluCtr", i), 32'(bus.aluCtr), 32'(vt[i].ctr));
            chk($sformatf("vec%0d exWriteReg", i), 32'(bus.exWriteReg), 32'(vt[i].wreg));
        end

        lw = mk(1, 4, 0, 32'h100, 32'h0, 16'h8, 6'h0, 2'b00, 1, 0);
        lw.memRead = 1'b1;
        lw.memToReg = 1'b1;
        dep = mk(4, 2, 11, 32'h0, 32'h7, 16'h0, 6'h20, 2'b10, 0, 1);

        // Load-use: one stall cycle, bubble, then dependent captured with MEM/WB data
        drive_fw(fw0);
        drive_id(lw);
        step(0, 0);
        drive_id(dep);
        #1;
        chk("lu stall", 32'(bus.stall), 32'd1);
        step(0, 0);
        #1;
        chk("lu bubble exValid", 32'(bus.exValid), 32'd0);
        chk("lu bubble exRegWrite", 32'(bus.exRegWrite), 32'd0);
        chk("lu bubble exMemWrite", 32'(bus.exMemWrite), 32'd0);
        chk("lu post stall", 32'(bus.stall), 32'd0);
        step(0, 0);
        drive_fw(mkfw(0, 0, 32'h0, 1, 4, 32'h1234));
        #1;
        chk("lu dep exValid", 32'(bus.exValid), 32'd1);
        chk("lu dep input1", bus.input1, 32'h1234);

        // Flush together with a load-use stall still gives a bubble
        drive_fw(fw0);
        drive_id(lw);
        step(0, 0);
        drive_id(dep);
        step(0, 1);
        #1;
        chk("flush exValid", 32'(bus.exValid), 32'd0);
        chk("flush exRegWrite", 32'(bus.exRegWrite), 32'd0);
        chk("flush exMemRead", 32'(bus.exMemRead), 32'd0);
        step(0, 0);
        check_outs();

        // Reset in the middle of a stall
        drive_id(lw);
        step(0, 0);
        drive_id(dep);
        #1;
        chk("mid stall", 32'(bus.stall), 32'd1);
        step(1, 0);
        #1;
        chk("mid rst exValid", 32'(bus.exValid), 32'd0);
        chk("mid rst exRegWrite", 32'(bus.exRegWrite), 32'd0);
        chk("mid rst exMemRead", 32'(bus.exMemRead), 32'd0);
        chk("mid rst aluCtr", 32'(bus.aluCtr), 32'h2);
        chk("mid rst exWriteReg", 32'(bus.exWriteReg), 32'd0);
        chk("mid rst stall", 32'(bus.stall), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            r = '0;
            r.valid    = ($urandom_range(0, 7) != 0);
            r.rs       = 5'($urandom_range(0, 7));
            r.rt       = 5'($urandom_range(0, 7));
            r.rd       = 5'($urandom_range(0, 7));
            r.rsData   = $urandom;
            r.rtData   = $urandom;
            r.imm      = 16'($urandom);
            r.aluOp    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: r.funct = 6'h20;
                1: r.funct = 6'h22;
                2: r.funct = 6'h24;
                3: r.funct = 6'h25;
                4: r.funct = 6'h2A;
                5: r.funct = 6'h27;
                default: r.funct = 6'($urandom);
            endcase
            r.aluSrc   = 1'($urandom);
            r.regDst   = 1'($urandom);
            r.memRead  = ($urandom_range(0, 2) == 0);
            r.memWrite = 1'($urandom);
            r.memToReg = 1'($urandom);
            r.regWrite = 1'($urandom);
            r.branch   = 1'($urandom);
            rst_r = ($urandom_range(0, 49) == 0);
            fl_r  = ($urandom_range(0, 9) == 0);
            drive_id(r);
            step(rst_r, fl_r);
            rf = mkfw(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            drive_fw(rf);
            check_outs();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage sitting directly upstream of the execute-stage ALU in the five-stage pipelined MIPS datapath. It registers decoded operands and control from ID and decodes `aluOp`/`funct` into the 4-bit ALU operation code. It resolves EX/MEM and MEM/WB data forwarding and detects load-use hazards. It drives `input1`, `input2` and `aluCtr` straight into the ALU.

## Interface
- `DATA_W`, 32, operand/data width
- `REG_W`, 5, register index width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `idValid`  in  1  ID holds a real instruction
- `idRs`, `idRt`, `idRd`  in  REG_W  register indices
- `idRsData`, `idRtData`  in  DATA_W  register-file read data
- `idImm`  in  16  raw immediate, sign-extended here
- `idFunct`  in  6  R-type function field
- `idAluOp`  in  2  00 add, 01 sub, 10 R-type, 11 reserved (add)
- `idAluSrc`, `idRegDst`, `idMemRead`, `idMemWrite`, `idMemToReg`, `idRegWrite`, `idBranch`  in  1 each  control
- `flush`  in  1  taken branch; kill the instruction entering EX
- `exMemRegWrite`  in  1, `exMemRd`  in  REG_W, `exMemAluRes`  in  DATA_W  EX/MEM forwarding source
- `memWbRegWrite`  in  1, `memWbRd`  in  REG_W, `memWbData`  in  DATA_W  MEM/WB forwarding source
- `stall`  out  1  hold PC and IF/ID this cycle
- `input1`, `input2`  out  DATA_W  ALU operands
- `aluCtr`  out  4  ALU op code
- `exStoreData`  out  DATA_W  forwarded rt value for stores
- `exWriteReg`  out  REG_W  destination register
- `exValid`, `exMemRead`, `exMemWrite`, `exMemToReg`, `exRegWrite`, `exBranch`  out  1  registered control

## Operation
- The ID/EX register captures all `id*` inputs on each rising edge. The immediate is sign-extended to DATA_W at capture.
- Load priority per edge: `reset` > `flush` > load-use bubble > normal capture.
- A bubble clears `exValid` and every write/memory control (`exRegWrite`, `exMemRead`, `exMemWrite`, `exBranch`) to 0. Data fields are don't-care.
- Load-use hazard: `stall` = `exValid & exMemRead & (ID/EX rt != 0) & idValid & ((idRs == ID/EX rt) | (idRt == ID/EX rt))`. The check is combinational. While `stall` is high, the next edge loads a bubble. If `flush` is also high, flush wins and the result is still a bubble.
- `exWriteReg` = `regDst` ? rd : rt.
- Forward select for source s (rs, rt):
  - EX/MEM when `exMemRegWrite` and `exMemRd != 0` and `exMemRd == s`.
  - Otherwise MEM/WB when `memWbRegWrite` and `memWbRd != 0` and `memWbRd == s`.
  - Otherwise the registered read data.
  - EX/MEM has priority when both stages match.
- `input1` = forwarded rs. `exStoreData` = forwarded rt. `input2` = `aluSrc` ? sign-extended imm : forwarded rt.
- `aluCtr` decode:
  - aluOp 00 / 11 → 0010 (add); aluOp 01 → 0110 (sub).
  - aluOp 10 uses funct: 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111, 100111 → 1100, any other funct → 0010.
- Register index 0 is never forwarded. Reads of $0 always use register-file data.

## Timing
- Reset: every ID/EX field is 0, giving `exValid`=0, all control 0, `exWriteReg`=0, `aluCtr`=0010. `input1`, `input2` and `exStoreData` then follow forwarding from the zeroed fields.
- `reset` asserted mid-stall forces a bubble. `stall` then deasserts combinationally because `exValid`=0.
- Latency: ID to EX outputs is 1 cycle.
- Combinational paths within the same cycle:
  - Forwarding inputs → `input1` / `input2` / `exStoreData`.
  - `id*` → `stall`.
- No combinational path from `flush` to `stall`.
- A load-use stall lasts exactly one cycle per dependent instruction. After the bubble, the MEM/WB path supplies the loaded value.

## Structure
- Shared package `pipe_pkg`:
  - ALU codes `ALU_AND`=0000, `ALU_OR`=0001, `ALU_ADD`=0010, `ALU_SUB`=0110, `ALU_SLT`=0111, `ALU_NOR`=1100.
  - aluOp encodings and funct constants.
  - Forward-select encoding: `FWD_REG`=00, `FWD_MEMWB`=01, `FWD_EXMEM`=10.
- Sub-module `forward_unit`: purely combinational. Takes the source index and both stage write ports, returns a 2-bit select. Instantiated twice, once for rs and once for rt.
- ALU-control decode and hazard detection stay inline.

## Test plan
- Reset, then R-type `add` with rs=1(0x5), rt=2(0x7), funct 100000, no hazards → next cycle `input1`=5, `input2`=7, `aluCtr`=0010, `exWriteReg`=rd, `exValid`=1.
- EX/MEM and MEM/WB both writing rd=3 (0xAA vs 0xBB), next instruction reads rs=3 → `input1`=0xAA. With `exMemRegWrite`=0 → 0xBB. With rd=0 in both → register-file data.
- `lw` to rt=4 in EX, ID instruction uses rs=4 → `stall`=1 for one cycle, then a bubble in EX (`exRegWrite`=0, `exMemWrite`=0). Next cycle `stall`=0 and the dependent instruction captures.
- `idImm`=0xFFFC, `aluSrc`=1, aluOp 00 → `input2`=0xFFFFFFFC, `aluCtr`=0010. aluOp 01 → 0110.
- Funct sweep with aluOp 10: 100100 → 0000, 100101 → 0001, 101010 → 0111, 100111 → 1100, 000000 → 0010.
- `flush`=1 together with a load-use stall → bubble captured. `reset` pulse in mid-stream → all control outputs 0 at the next edge.
